// File: rtl/ne_window_detector.sv
// Window-mean accumulator over non-overlapping 2^LOG2_WIN sample windows of the NE stream,
// with a HOLD-window hysteresis alarm that is evaluated on every window mean.
module ne_window_detector #(
   parameter int IN_WIDTH = 33,
   parameter int LOG2_WIN = 4,
   parameter int HOLD     = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic signed [IN_WIDTH-1:0] din,
   input  logic                       din_valid,
   input  logic signed [IN_WIDTH-1:0] threshold,
   output logic signed [IN_WIDTH-1:0] mean_out,
   output logic                       mean_valid,
   output logic                       alarm,
   output logic                       alarm_change,
   output logic        [LOG2_WIN-1:0] win_count
);

   localparam int ACC_W = IN_WIDTH + LOG2_WIN;
   localparam int RUN_W = 4;
   localparam logic [RUN_W-1:0]    RUN_LAST = RUN_W'(HOLD - 1);
   localparam logic [LOG2_WIN-1:0] WIN_LAST = '1;

   typedef enum logic {QUIET = 1'b0, ALARM = 1'b1} det_state_t;

   det_state_t              state;
   logic [RUN_W-1:0]        run;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] din_ext;
   logic signed [ACC_W-1:0] total;
   logic signed [ACC_W-1:0] total_shr;
   logic signed [IN_WIDTH-1:0] mean_new;
   logic                    accept;
   logic                    closing;
   logic                    above;

   always_comb begin
      accept    = en && din_valid;
      closing   = accept && (win_count == WIN_LAST);
      din_ext   = {{LOG2_WIN{din[IN_WIDTH-1]}}, din};
      total     = acc + din_ext;
      // Arithmetic shift floors; the mean always fits back into the input width.
      total_shr = total >>> LOG2_WIN;
      mean_new  = total_shr[IN_WIDTH-1:0];
      above     = mean_new > threshold;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc          <= '0;
         win_count    <= '0;
         mean_out     <= '0;
         mean_valid   <= 1'b0;
         alarm        <= 1'b0;
         alarm_change <= 1'b0;
         run          <= '0;
         state        <= QUIET;
      end else begin
         mean_valid   <= 1'b0;
         alarm_change <= 1'b0;
         if (closing) begin
            acc        <= '0;
            win_count  <= '0;
            mean_out   <= mean_new;
            mean_valid <= 1'b1;
            // The detector only steps on window close, using the fresh mean.
            case (state)
               QUIET: begin
                  if (!above)
                     run <= '0;
                  else if (run == RUN_LAST) begin
                     state        <= ALARM;
                     run          <= '0;
                     alarm        <= 1'b1;
                     alarm_change <= 1'b1;
                  end else
                     run <= run + 1'b1;
               end
               ALARM: begin
                  if (above)
                     run <= '0;
                  else if (run == RUN_LAST) begin
                     state        <= QUIET;
                     run          <= '0;
                     alarm        <= 1'b0;
                     alarm_change <= 1'b1;
                  end else
                     run <= run + 1'b1;
               end
               default: begin
                  state <= QUIET;
                  run   <= '0;
               end
            endcase
         end else if (accept) begin
            acc       <= total;
            win_count <= win_count + 1'b1;
         end
      end
   end

endmodule

// File: doc/ne_window_detector.md
Name: ne_window_detector

Overview:
- Downstream consumer of the nonlinear-energy stream produced by ne_comp_unit (its dout/data_valid pair).
- Accumulates NE samples over fixed, non-overlapping windows and emits the window mean.
- Runs a hysteresis detector that raises a registered alarm after HOLD consecutive windows whose mean exceeds a programmable threshold, and clears it after HOLD consecutive windows that do not.
- Sits between the feature unit and the classifier/interrupt logic.

Parameters:
- IN_WIDTH, 33: width of the signed NE sample. Matches ne_comp_unit output of input_width+1.
- LOG2_WIN, 4: log2 of window length. WIN = 2^LOG2_WIN samples; legal range 1..10.
- HOLD, 3: number of consecutive qualifying windows needed to change alarm state; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  global enable; samples are accepted only while high
- din  in  IN_WIDTH  signed NE sample; connects to ne_comp_unit dout
- din_valid  in  1  sample strobe; connects to ne_comp_unit data_valid
- threshold  in  IN_WIDTH  signed detection threshold; sampled at window close
- mean_out  out  IN_WIDTH  signed window mean; held until the next window closes
- mean_valid  out  1  one-cycle pulse when mean_out updates
- alarm  out  1  registered detection state
- alarm_change  out  1  one-cycle pulse when alarm toggles
- win_count  out  LOG2_WIN  samples accepted in the current window, 0..WIN-1

Behaviour:
- Reset (async, immediate): acc=0, win_count=0, mean_out=0, mean_valid=0, alarm=0, alarm_change=0, run=0, detector state QUIET. Any partial window is discarded.
- Accept: a sample is accepted at a rising edge when en && din_valid. While en=0, din_valid is ignored and acc/win_count/run hold their values; the partial window resumes when en returns high.
- Accumulator: signed, IN_WIDTH+LOG2_WIN bits, wide enough that a full window never overflows.
- Non-closing accept (win_count < WIN-1): acc += sign-extended din; win_count++.
- Closing accept (win_count == WIN-1), all at the same edge:
  - total = acc + din.
  - mean_out = total >>> LOG2_WIN (arithmetic shift, i.e. floor), truncated to IN_WIDTH. This truncation is lossless because the mean lies within the input range.
  - mean_valid = 1 for exactly one cycle.
  - acc = 0 and win_count = 0.
- Back-to-back windows: din_valid may be high on every cycle with no gap between windows. Latency from the closing sample edge to the mean_valid/mean_out update is 1 cycle.
- Qualifying test: above = (new mean > threshold), signed and strict. threshold is sampled only at the closing edge.
- Detector FSM advances only at closing edges, using the new mean. run counter holds 0..HOLD-1.
  - QUIET:
    - above=1 and run==HOLD-1 -> ALARM, run=0, alarm=1, alarm_change=1.
    - above=1 otherwise -> run++.
    - above=0 -> run=0.
  - ALARM:
    - above=0 and run==HOLD-1 -> QUIET, run=0, alarm=0, alarm_change=1.
    - above=0 otherwise -> run++.
    - above=1 -> run=0.
- HOLD=1 means the alarm follows every window's comparison directly.
- alarm and alarm_change update at the same edge as mean_valid. alarm_change is never high without mean_valid.
- Reset mid-window or mid-run: all accumulation and run history is lost. After reset, the first window needs WIN fresh samples.
- Width rule: din is always sign-extended. No saturation is needed because the accumulator sizing guarantees no overflow.

Test Plan:
- Steady above threshold (LOG2_WIN=4, HOLD=3, threshold=50, din=100, din_valid=1 continuously, en=1, 64 samples):
  - mean_valid pulses on cycles 16, 32, 48 and 64 after the first accept, each with mean_out=100.
  - alarm and alarm_change rise together with the 3rd mean_valid.
- Floor rounding, two windows:
  - Window of fifteen 0 samples then one 1 -> mean_out=0.
  - Window of one -1 then fifteen 0 -> mean_out=-1.
  - Neither window raises the alarm when threshold=0.
- Hysteresis:
  - From ALARM, apply window means 10, 100, 10, 10, 10 with threshold=50.
  - The 100 window resets run; alarm falls only at the 5th window, with alarm_change pulsing there.
- en gating:
  - Accept 8 samples of 40, hold en=0 for 5 cycles with din_valid=1 and din=9999, then accept 8 samples of 40.
  - Exactly one mean_valid is produced, with mean_out=40. win_count holds at 8 while en=0.
- Extremes: din=2^32-1 (max positive 33-bit) for one window, then din=-2^32 for one window -> mean_out equals each value exactly, with no wrap.
- Async reset: assert rst at win_count=9 while alarm=1.
  - Outputs clear immediately, without waiting for a clock edge.
  - After release, the next mean_valid occurs only after 16 new accepts, with run starting at 0.
